// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared widths, master count, default read latency and arbiter state type.
package dmem_arbiter_pkg;
  localparam int DMEM_NB_ADDR = 32;
  localparam int DMEM_NB_WORD = 32;
  localparam int N_DMEM_MASTERS = 2;
  localparam int DMEM_RD_LATENCY = 1;
  typedef enum logic {ARB_IDLE, ARB_WAIT} dmem_arb_state_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way round-robin pick; on contention the master that did not win last time wins.
module dmem_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       winner
);
  always_comb begin
    winner = (req == 2'b11) ? ~last_grant : req[1];
    grant = (req == 2'b00) ? 2'b00 : (winner ? 2'b10 : 2'b01);
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between two masters with round-robin grants
// and a fixed read latency.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int NB_ADDR = DMEM_NB_ADDR,
  parameter int NB_WORD = DMEM_NB_WORD,
  parameter int RD_LATENCY = DMEM_RD_LATENCY
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_m0_req,
  input  logic               i_m0_we,
  input  logic [NB_ADDR-1:0] i_m0_addr,
  input  logic [NB_WORD-1:0] i_m0_wdata,
  output logic               o_m0_gnt,
  output logic               o_m0_rvalid,
  output logic [NB_WORD-1:0] o_m0_rdata,
  input  logic               i_m1_req,
  input  logic               i_m1_we,
  input  logic [NB_ADDR-1:0] i_m1_addr,
  input  logic [NB_WORD-1:0] i_m1_wdata,
  output logic               o_m1_gnt,
  output logic               o_m1_rvalid,
  output logic [NB_WORD-1:0] o_m1_rdata,
  output logic [NB_ADDR-1:0] o_dmem_address,
  output logic [NB_WORD-1:0] o_dmem_wr_data,
  output logic               o_dmem_wr_enable,
  input  logic [NB_WORD-1:0] i_dmem_rd_data
);
  localparam int NB_CNT = $clog2(RD_LATENCY + 1);

  if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
    $error("dmem_arbiter: RD_LATENCY must be in 1..4");
  end

  dmem_arb_state_t    state;
  logic [NB_CNT-1:0]  cnt;
  logic               owner;
  logic               last_grant;
  logic [NB_ADDR-1:0] held_addr;
  logic [1:0]         reqs;
  logic [1:0]         grant;
  logic               winner;
  logic               idle;
  logic               done;
  logic               issue;
  logic               w_we;
  logic [NB_ADDR-1:0] w_addr;
  logic [NB_WORD-1:0] w_data;

  assign reqs = {i_m1_req, i_m0_req};

  dmem_rr_pick u_pick (
    .req        (reqs),
    .last_grant (last_grant),
    .grant      (grant),
    .winner     (winner)
  );

  // Everything is gated by i_reset so outputs drop to 0 the moment reset asserts.
  always_comb begin
    idle = i_reset && (state == ARB_IDLE);
    done = i_reset && (state == ARB_WAIT) && (cnt == '0);
    issue = idle && (|reqs);
    w_we = winner ? i_m1_we : i_m0_we;
    w_addr = winner ? i_m1_addr : i_m0_addr;
    w_data = winner ? i_m1_wdata : i_m0_wdata;
    o_m0_gnt = idle && grant[0];
    o_m1_gnt = idle && grant[1];
    o_dmem_address = !i_reset ? '0 : (state == ARB_WAIT) ? held_addr : (issue ? w_addr : '0);
    o_dmem_wr_data = issue ? w_data : '0;
    o_dmem_wr_enable = issue && w_we;
    o_m0_rvalid = done && !owner;
    o_m1_rvalid = done && owner;
    o_m0_rdata = o_m0_rvalid ? i_dmem_rd_data : '0;
    o_m1_rdata = o_m1_rvalid ? i_dmem_rd_data : '0;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ARB_IDLE;
      cnt <= '0;
      owner <= 1'b0;
      last_grant <= 1'b1;
      held_addr <= '0;
    end else if (state == ARB_IDLE) begin
      if (|reqs) begin
        last_grant <= winner;
        if (!w_we) begin
          held_addr <= w_addr;
          owner <= winner;
          cnt <= NB_CNT'(RD_LATENCY - 1);
          state <= ARB_WAIT;
        end
      end
    end else if (cnt == '0) begin
      state <= ARB_IDLE;
    end else begin
      cnt <= cnt - NB_CNT'(1);
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed plus randomized checks of dmem_arbiter against a cycle-numbered
// transaction model (read response due at grant cycle + latency).
module tb_dmem_arbiter;
  localparam int LAT = 3;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dmem_address, dmem_wr_data, dmem_rd_data;
  logic        dmem_wr_enable;

  int checks = 0;
  int failures = 0;

  int          cyc;
  int          resp;
  bit          busy, own, last;
  logic [31:0] raddr;
  logic        seen_g0, seen_g1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0F96;
  endfunction

  assign dmem_rd_data = mem(dmem_address);

  dmem_arbiter #(.RD_LATENCY(LAT)) dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_m0_req         (m0_req),
    .i_m0_we          (m0_we),
    .i_m0_addr        (m0_addr),
    .i_m0_wdata       (m0_wdata),
    .o_m0_gnt         (m0_gnt),
    .o_m0_rvalid      (m0_rvalid),
    .o_m0_rdata       (m0_rdata),
    .i_m1_req         (m1_req),
    .i_m1_we          (m1_we),
    .i_m1_addr        (m1_addr),
    .i_m1_wdata       (m1_wdata),
    .o_m1_gnt         (m1_gnt),
    .o_m1_rvalid      (m1_rvalid),
    .o_m1_rdata       (m1_rdata),
    .o_dmem_address   (dmem_address),
    .o_dmem_wr_data   (dmem_wr_data),
    .o_dmem_wr_enable (dmem_wr_enable),
    .i_dmem_rd_data   (dmem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_m0_gnt"}, 32'(m0_gnt), 0);
    chk({tag, "_m1_gnt"}, 32'(m1_gnt), 0);
    chk({tag, "_m0_rvalid"}, 32'(m0_rvalid), 0);
    chk({tag, "_m1_rvalid"}, 32'(m1_rvalid), 0);
    chk({tag, "_m0_rdata"}, m0_rdata, 0);
    chk({tag, "_m1_rdata"}, m1_rdata, 0);
    chk({tag, "_addr"}, dmem_address, 0);
    chk({tag, "_wdata"}, dmem_wr_data, 0);
    chk({tag, "_we"}, 32'(dmem_wr_enable), 0);
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic model_reset();
    busy = 1'b0; last = 1'b1; own = 1'b0; raddr = '0; resp = -1;
  endtask

  task automatic step(input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1);
    logic has, win, eg0, eg1, ewe, erv0, erv1;
    logic [31:0] ea, ewd;
    @(negedge clk);
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    #1;
    has = r0 | r1;
    win = (r0 && r1) ? !last : r1;
    if (!busy) begin
      eg0 = has && !win;
      eg1 = has && win;
      ea = has ? (win ? a1 : a0) : '0;
      ewd = has ? (win ? d1 : d0) : '0;
      ewe = has && (win ? w1 : w0);
      erv0 = 1'b0;
      erv1 = 1'b0;
    end else begin
      eg0 = 1'b0;
      eg1 = 1'b0;
      ea = raddr;
      ewd = '0;
      ewe = 1'b0;
      erv0 = (cyc == resp) && !own;
      erv1 = (cyc == resp) && own;
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(eg0));
    chk("m1_gnt", 32'(m1_gnt), 32'(eg1));
    chk("dmem_addr", dmem_address, ea);
    chk("dmem_wdata", dmem_wr_data, ewd);
    chk("dmem_we", 32'(dmem_wr_enable), 32'(ewe));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(erv0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(erv1));
    if (erv0 || (busy && own)) chk("m0_rdata", m0_rdata, erv0 ? mem(raddr) : '0);
    if (erv1 || (busy && !own)) chk("m1_rdata", m1_rdata, erv1 ? mem(raddr) : '0);
    seen_g0 = eg0;
    seen_g1 = eg1;
    @(posedge clk);
    if (!busy && has) begin
      last = win;
      if (!(win ? w1 : w0)) begin
        busy = 1'b1;
        own = win;
        raddr = win ? a1 : a0;
        resp = cyc + LAT;
      end
    end else if (busy && cyc == resp) begin
      busy = 1'b0;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic        rr0, rw0, rr1, rw1;
    logic [31:0] ra0, rd0, ra1, rd1;
    bit          p0, p1;
    cyc = 0;
    model_reset();
    rst = 1'b0;
    drive(1, 1, 32'h20, 32'h1111_1111, 1, 0, 32'h24, 32'h2222_2222);
    #3 chk_zero("reset");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;

    // Contending writes alternate starting with m0.
    for (int i = 0; i < 6; i++) step(1, 1, 32'h20, 32'h1111_1111, 1, 1, 32'h24, 32'h2222_2222);
    idle_steps(1);

    // Single m0 read.
    step(1, 0, 32'h10, 0, 0, 0, 0, 0);
    idle_steps(LAT + 1);

    // m1 read while m0 keeps a write pending through the wait.
    step(1, 1, 32'h50, 32'hABCD_0123, 1, 0, 32'h40, 0);
    for (int i = 0; i < LAT + 1; i++) step(1, 1, 32'h50, 32'hABCD_0123, 0, 0, 0, 0);
    idle_steps(1);

    // Back-to-back m0 reads.
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 32'(4 * k), 0, 0, 0, 0, 0);
      idle_steps(LAT);
    end

    // m1 request raised and dropped inside the wait window.
    step(1, 0, 32'h80, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h84, 32'h5555_AAAA);
    idle_steps(LAT);
    step(1, 1, 32'h20, 32'h1, 1, 1, 32'h24, 32'h2);
    step(1, 1, 32'h20, 32'h1, 0, 0, 0, 0);

    // Reset in the middle of a read wait.
    step(1, 0, 32'h60, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 32'h70, 0, 1, 0, 32'h74, 0);
    #2 rst = 1'b0;
    #1 chk_zero("midreset");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b1;
    model_reset();
    idle_steps(LAT + 1);
    step(1, 1, 32'h20, 32'h3, 1, 1, 32'h24, 32'h4);
    step(1, 1, 32'h20, 32'h3, 0, 0, 0, 0);

    // Randomized traffic honouring the hold-until-grant rule.
    p0 = 0; p1 = 0;
    rr0 = 0; rw0 = 0; ra0 = 0; rd0 = 0; rr1 = 0; rw1 = 0; ra1 = 0; rd1 = 0;
    for (int i = 0; i < 500; i++) begin
      if (p0) begin
        if ($urandom % 8 == 0) rr0 = 0;
      end else begin
        rr0 = 1'($urandom % 2); rw0 = 1'($urandom % 2); ra0 = $urandom; rd0 = $urandom;
      end
      if (p1) begin
        if ($urandom % 8 == 0) rr1 = 0;
      end else begin
        rr1 = 1'($urandom % 2); rw1 = 1'($urandom % 2); ra1 = $urandom; rd1 = $urandom;
      end
      step(rr0, rw0, ra0, rd0, rr1, rw1, ra1, rd1);
      p0 = rr0 && !seen_g0;
      p1 = rr1 && !seen_g1;
    end
    idle_steps(LAT + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
